// File: rtl/tut_control_unit.sv
// ============================================================================
// Module   : tut_control_unit
// Brief    : Hardwired T-state sequencer driving the tutorial DataPath strobes.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tut_control_unit #(
    parameter int IMM_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic [31:0]          instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    output logic                 RAin,
    output logic                 RBin,
    output logic                 RZin,
    output logic                 RAout,
    output logic                 RBout,
    output logic                 RZout,
    output logic [31:0]          RegisterAimmediate,
    output logic [31:0]          AddImmediate,
    output logic                 done,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T0   = 2'd1,
        S_T1   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0]           c_op_nop  = 4'd0;
    localparam logic [3:0]           c_op_ldi  = 4'd1;
    localparam logic [3:0]           c_op_addi = 4'd2;
    localparam logic [3:0]           c_op_mv   = 4'd3;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = 1;

    state_t               r_state;
    state_t               w_next;
    logic [31:0]          r_ir;
    logic [CNT_WIDTH-1:0] r_count;

    logic [3:0]  w_op;
    logic        w_dst;
    logic        w_src;
    logic [31:0] w_imm;
    logic        w_illegal;
    logic        w_unused_ir;

    assign w_op        = r_ir[31:28];
    assign w_dst       = r_ir[27];
    assign w_src       = r_ir[26];
    assign w_imm       = {{(32-IMM_WIDTH){r_ir[IMM_WIDTH-1]}}, r_ir[IMM_WIDTH-1:0]};
    assign w_illegal   = (w_op > c_op_mv) || ((w_op == c_op_ldi) && w_dst);
    assign w_unused_ir = &{1'b0, r_ir[25:IMM_WIDTH]};
    assign instr_count = r_count;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && instr_valid) begin
                r_ir <= instr;
            end
            if (r_state == S_DONE) begin
                r_count <= r_count + c_cnt_one;
            end
        end
    end

    // Outputs depend only on r_state/r_ir; instr_valid steers next state alone.
    always_comb begin
        w_next             = r_state;
        instr_ready        = 1'b0;
        RAin               = 1'b0;
        RBin               = 1'b0;
        RZin               = 1'b0;
        RAout              = 1'b0;
        RBout              = 1'b0;
        RZout              = 1'b0;
        RegisterAimmediate = 32'h0;
        AddImmediate       = 32'h0;
        done               = 1'b0;
        illegal            = 1'b0;
        case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_next = S_T0;
                end
            end
            S_T0: begin
                case (w_op)
                    c_op_nop: ;
                    c_op_ldi: begin
                        if (!w_dst) begin
                            RegisterAimmediate = w_imm;
                            RAin               = 1'b1;
                        end
                    end
                    c_op_addi: begin
                        AddImmediate = w_imm;
                        RZin         = 1'b1;
                        RAout        = !w_src;
                        RBout        = w_src;
                    end
                    c_op_mv: begin
                        // A move onto itself is a no-op; no bus transfer is made.
                        if (w_src != w_dst) begin
                            RAout = !w_src;
                            RBout = w_src;
                            RAin  = !w_dst;
                            RBin  = w_dst;
                        end
                    end
                    default: ;
                endcase
                w_next = (w_op == c_op_addi) ? S_T1 : S_DONE;
            end
            S_T1: begin
                RZout  = 1'b1;
                RAin   = !w_dst;
                RBin   = w_dst;
                w_next = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                illegal = w_illegal;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_tut_control_unit.sv
// ============================================================================
// Module   : tb_tut_control_unit
// Brief    : Scoreboard bench for tut_control_unit sequencing and counters.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tut_control_unit;

    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          clear;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          RAin, RBin, RZin, RAout, RBout, RZout;
    logic [31:0]   RegisterAimmediate, AddImmediate;
    logic          done, illegal;
    logic [CW-1:0] instr_count;

    always #5 clock = ~clock;

    tut_control_unit #(.IMM_WIDTH(16), .CNT_WIDTH(CW)) dut (
        .clock              (clock),
        .clear              (clear),
        .instr              (instr),
        .instr_valid        (instr_valid),
        .instr_ready        (instr_ready),
        .RAin               (RAin),
        .RBin               (RBin),
        .RZin               (RZin),
        .RAout              (RAout),
        .RBout              (RBout),
        .RZout              (RZout),
        .RegisterAimmediate (RegisterAimmediate),
        .AddImmediate       (AddImmediate),
        .done               (done),
        .illegal            (illegal),
        .instr_count        (instr_count)
    );

    typedef struct packed {
        logic        ready;
        logic        rain, rbin, rzin, raout, rbout, rzout;
        logic [31:0] rai;
        logic [31:0] addi;
        logic        done;
        logic        illegal;
    } vec_t;

    vec_t          sb[$];
    int            tests = 0;
    int            failed = 0;
    logic [CW-1:0] exp_count;

    function automatic vec_t idle_vec();
        vec_t v;
        v = '0;
        v.ready = 1'b1;
        return v;
    endfunction

    function automatic vec_t observed();
        vec_t v;
        v.ready = instr_ready; v.rain = RAin; v.rbin = RBin; v.rzin = RZin;
        v.raout = RAout; v.rbout = RBout; v.rzout = RZout;
        v.rai = RegisterAimmediate; v.addi = AddImmediate;
        v.done = done; v.illegal = illegal;
        return v;
    endfunction

    // Expected per-cycle outputs for one instruction: T0, [T1], DONE, then idle.
    task automatic push_model(input logic [31:0] w);
        vec_t v; logic [3:0] op; logic d, s, bad; logic [31:0] imm;
        op = w[31:28]; d = w[27]; s = w[26];
        imm = {{16{w[15]}}, w[15:0]};
        bad = (op > 4'd3) || (op == 4'd1 && d);
        v = '0;
        if (op == 4'd1 && !bad) begin
            v.rai = imm; v.rain = 1'b1;
        end else if (op == 4'd2) begin
            v.addi = imm; v.rzin = 1'b1;
            if (s) v.rbout = 1'b1; else v.raout = 1'b1;
        end else if (op == 4'd3 && s != d) begin
            if (s) begin v.rbout = 1'b1; v.rain = 1'b1; end
            else   begin v.raout = 1'b1; v.rbin = 1'b1; end
        end
        sb.push_back(v);
        if (op == 4'd2) begin
            v = '0; v.rzout = 1'b1;
            if (d) v.rbin = 1'b1; else v.rain = 1'b1;
            sb.push_back(v);
        end
        v = '0; v.done = 1'b1; v.illegal = bad;
        sb.push_back(v);
        sb.push_back(idle_vec());
        exp_count = exp_count + 1'b1;
    endtask

    // Called at a falling edge; returns just after the accepting rising edge.
    task automatic send(input logic [31:0] w, input bit hold, output bit ok);
        ok = 1'b0;
        instr = w;
        instr_valid = 1'b1;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (instr_ready) begin
                @(posedge clock); #1;
                if (!hold) instr_valid = 1'b0;
                ok = 1'b1;
            end else begin
                @(negedge clock);
            end
        end
        if (!ok) instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        vec_t exp, act;
        clear = 1'b1; instr_valid = 1'b1; instr = 32'h1000_0005;
        repeat (2) @(posedge clock);
        #1 clear = 1'b0; instr_valid = 1'b0;
        exp_count = '0;
        sb.push_back(idle_vec());
        sb.push_back(idle_vec());
        while (sb.size() > 0) begin
            @(negedge clock); exp = sb.pop_front(); act = observed(); tests++;
            if (act !== exp) begin failed++; $display("FAIL reset_outputs: actual=%h required=%h", act, exp); end
        end
        tests++;
        if (instr_count !== exp_count) begin failed++; $display("FAIL reset_count: actual=%0d required=%0d", instr_count, exp_count); end
    endtask

    task automatic test_ldi();
        vec_t exp, act; bit ok;
        push_model(32'h1000_0005);
        send(32'h1000_0005, 1'b0, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL ldi_accept: accepted=%0b required=1", ok); end
        while (sb.size() > 0) begin
            @(negedge clock); exp = sb.pop_front(); act = observed(); tests++;
            if (act !== exp) begin failed++; $display("FAIL ldi_seq: actual=%h required=%h", act, exp); end
        end
        tests++;
        if (instr_count !== exp_count) begin failed++; $display("FAIL ldi_count: actual=%0d required=%0d", instr_count, exp_count); end
    endtask

    task automatic test_addi();
        vec_t exp, act; bit ok;
        push_model(32'h2800_0005);
        send(32'h2800_0005, 1'b0, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL addi_accept: accepted=%0b required=1", ok); end
        while (sb.size() > 0) begin
            @(negedge clock); exp = sb.pop_front(); act = observed(); tests++;
            if (act !== exp) begin failed++; $display("FAIL addi_seq: actual=%h required=%h", act, exp); end
        end
        tests++;
        if (instr_count !== exp_count) begin failed++; $display("FAIL addi_count: actual=%0d required=%0d", instr_count, exp_count); end
    endtask

    task automatic test_mv_imm();
        vec_t exp, act; bit ok;
        logic [31:0] list [4] = '{32'h3400_0000, 32'h3000_0000, 32'h2000_FFFF, 32'h0000_0000};
        foreach (list[k]) begin
            push_model(list[k]);
            send(list[k], 1'b0, ok);
            tests++;
            if (!ok) begin failed++; $display("FAIL mv_accept: instr=%h accepted=%0b required=1", list[k], ok); end
            while (sb.size() > 0) begin
                @(negedge clock); exp = sb.pop_front(); act = observed(); tests++;
                if (act !== exp) begin failed++; $display("FAIL mv_seq: instr=%h actual=%h required=%h", list[k], act, exp); end
            end
        end
        tests++;
        if (instr_count !== exp_count) begin failed++; $display("FAIL mv_count: actual=%0d required=%0d", instr_count, exp_count); end
    endtask

    task automatic test_illegal();
        vec_t exp, act; bit ok;
        logic [31:0] list [2] = '{32'hF000_0000, 32'h1800_0003};
        foreach (list[k]) begin
            push_model(list[k]);
            send(list[k], 1'b0, ok);
            tests++;
            if (!ok) begin failed++; $display("FAIL illegal_accept: instr=%h accepted=%0b required=1", list[k], ok); end
            while (sb.size() > 0) begin
                @(negedge clock); exp = sb.pop_front(); act = observed(); tests++;
                if (act !== exp) begin failed++; $display("FAIL illegal_seq: instr=%h actual=%h required=%h", list[k], act, exp); end
            end
        end
        tests++;
        if (instr_count !== exp_count) begin failed++; $display("FAIL illegal_count: actual=%0d required=%0d", instr_count, exp_count); end
    endtask

    // Valid held high; instr swapped while busy must only affect the next window.
    task automatic test_back_to_back();
        vec_t exp, act; bit ok; int idx;
        push_model(32'h2800_0005);
        push_model(32'h1800_0003);
        sb.push_back(idle_vec());
        send(32'h2800_0005, 1'b1, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL b2b_accept: accepted=%0b required=1", ok); end
        idx = 0;
        while (sb.size() > 0) begin
            @(negedge clock); exp = sb.pop_front(); act = observed(); tests++;
            if (act !== exp) begin failed++; $display("FAIL b2b_seq: step=%0d actual=%h required=%h", idx, act, exp); end
            if (idx == 0) instr = 32'h1800_0003;
            if (idx == 5) instr_valid = 1'b0;
            idx++;
        end
        tests++;
        if (instr_count !== exp_count) begin failed++; $display("FAIL b2b_count: actual=%0d required=%0d", instr_count, exp_count); end
    endtask

    task automatic test_reset_mid();
        vec_t exp, act, t0; bit ok; int idx;
        t0 = '0; t0.raout = 1'b1; t0.rzin = 1'b1; t0.addi = 32'h0000_0005;
        sb.push_back(t0);
        repeat (3) sb.push_back(idle_vec());
        send(32'h2800_0005, 1'b0, ok);
        tests++;
        if (!ok) begin failed++; $display("FAIL midrst_accept: accepted=%0b required=1", ok); end
        idx = 0;
        while (sb.size() > 0) begin
            @(negedge clock); exp = sb.pop_front(); act = observed(); tests++;
            if (act !== exp) begin failed++; $display("FAIL midrst_seq: step=%0d actual=%h required=%h", idx, act, exp); end
            if (idx == 0) begin
                clear = 1'b1;
                @(posedge clock); #1 clear = 1'b0;
            end
            idx++;
        end
        exp_count = '0;
        tests++;
        if (instr_count !== exp_count) begin failed++; $display("FAIL midrst_count: actual=%0d required=%0d", instr_count, exp_count); end
    endtask

    task automatic test_wrap();
        bit ok; int misses;
        misses = 0;
        for (int i = 0; i < (1 << CW); i++) begin
            if (i == (1 << CW) - 1) begin
                tests++;
                if (instr_count !== {CW{1'b1}}) begin failed++; $display("FAIL wrap_full: actual=%0d required=%0d", instr_count, (1 << CW) - 1); end
            end
            send(32'h0000_0000, 1'b0, ok);
            if (!ok) misses++;
            repeat (3) @(negedge clock);
        end
        tests++;
        if (misses != 0) begin failed++; $display("FAIL wrap_accept: missed=%0d required=0", misses); end
        tests++;
        if (instr_count !== '0) begin failed++; $display("FAIL wrap_zero: actual=%0d required=0", instr_count); end
    endtask

    initial begin
        clear = 1'b0; instr_valid = 1'b0; instr = 32'h0; exp_count = '0;
        test_reset();
        test_ldi();
        test_addi();
        test_mv_imm();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
